// File: rtl/bp_io_mmio_responder.sv
// bp_io_mmio_responder
// Synthesizable stand-in for the host model on the uncached I/O command
// channel. It serves one single-beat command at a time against a small
// device map: putchar stream, per-core finish/pass flags, a free-running
// cycle counter and a bank of 64-bit scratch registers.

module bp_io_mmio_responder #(
    parameter int num_core_p    = 1,
    parameter int paddr_width_p = 40,
    parameter int num_scratch_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic [3:0]               io_cmd_msg_type_i,
    input  logic [paddr_width_p-1:0] io_cmd_addr_i,
    input  logic [2:0]               io_cmd_size_i,
    input  logic [15:0]              io_cmd_payload_i,
    input  logic [63:0]              io_cmd_data_i,
    input  logic                     io_cmd_v_i,
    output logic                     io_cmd_ready_o,

    output logic [3:0]               io_resp_msg_type_o,
    output logic [paddr_width_p-1:0] io_resp_addr_o,
    output logic [2:0]               io_resp_size_o,
    output logic [15:0]              io_resp_payload_o,
    output logic [63:0]              io_resp_data_o,
    output logic                     io_resp_v_o,
    input  logic                     io_resp_yumi_i,

    output logic [7:0]               char_o,
    output logic                     char_v_o,
    input  logic                     char_ready_i,

    output logic [num_core_p-1:0]    finish_o,
    output logic [num_core_p-1:0]    pass_o,
    output logic                     error_o
);

    localparam logic [31:0] NCORE    = 32'(num_core_p);
    localparam logic [31:0] NSCRATCH = 32'(num_scratch_p);

    localparam logic [3:0] MSG_RD    = 4'd0;
    localparam logic [3:0] MSG_WR    = 4'd1;
    localparam logic [3:0] MSG_UC_RD = 4'd2;
    localparam logic [3:0] MSG_UC_WR = 4'd3;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_char  = 2'd1,
        e_resp  = 2'd2
    } state_e;

    state_e                     state_q, state_d;

    logic [3:0]                 msg_type_q;
    logic [paddr_width_p-1:0]   addr_q;
    logic [2:0]                 size_q;
    logic [15:0]                payload_q;
    logic [7:0]                 char_q;
    logic [63:0]                resp_data_q, resp_data_d;

    logic [63:0]                cnt_q;
    logic [63:0]                scratch_q [num_scratch_p];
    logic [63:0]                scratch_d [num_scratch_p];
    logic [num_core_p-1:0]      finish_q, finish_d;
    logic [num_core_p-1:0]      pass_q, pass_d;
    logic                       error_q, error_d;

    logic [15:0]                a16;
    logic [31:0]                widx;
    logic [5:0]                 bit_off;
    logic                       is_rd, is_wr;
    logic                       hit_char, hit_cnt, hit_fin, hit_scr, unmapped;
    logic                       accept, char_wr;
    logic [63:0]                rd_word, rd_data;
    logic [63:0]                wr_mask, wr_data;
    logic                       unused_addr_hi;

    // Byte-lane mask for an access size; sizes above 8B collapse to 8B.
    function automatic logic [63:0] size_mask(input logic [2:0] size);
        logic [63:0] m;
        case (size)
            3'd0:    m = 64'h0000_0000_0000_00ff;
            3'd1:    m = 64'h0000_0000_0000_ffff;
            3'd2:    m = 64'h0000_0000_ffff_ffff;
            default: m = 64'hffff_ffff_ffff_ffff;
        endcase
        return m;
    endfunction

    // Only the low 16 address bits take part in decode.
    assign unused_addr_hi = ^io_cmd_addr_i[paddr_width_p-1:16];

    assign a16     = io_cmd_addr_i[15:0];
    assign widx    = {23'd0, a16[11:3]};
    assign bit_off = {a16[2:0], 3'b000};

    assign is_rd    = (io_cmd_msg_type_i == MSG_RD) || (io_cmd_msg_type_i == MSG_UC_RD);
    assign is_wr    = (io_cmd_msg_type_i == MSG_WR) || (io_cmd_msg_type_i == MSG_UC_WR);
    assign hit_char = (a16[15:12] == 4'h0);
    assign hit_cnt  = (a16[15:3] == 13'h0200);
    assign hit_fin  = (a16[15:12] == 4'h2) && (widx < NCORE);
    assign hit_scr  = (a16[15:12] == 4'h3) && (widx < NSCRATCH);
    assign unmapped = (is_rd || is_wr) && !(hit_char || hit_cnt || hit_fin || hit_scr);

    assign accept  = (state_q == e_ready) && io_cmd_v_i;
    assign char_wr = is_wr && hit_char;

    // Store data and its byte-lane mask aligned to the addressed byte; lanes past byte 7 fall off.
    assign wr_mask = size_mask(io_cmd_size_i) << bit_off;
    assign wr_data = io_cmd_data_i << bit_off;

    // Select the 64-bit word a read targets; putchar, finish and unmapped reads see zero.
    always_comb begin
        rd_word = '0;
        if (hit_cnt) begin
            rd_word = cnt_q;
        end
        for (int i = 0; i < num_scratch_p; i++) begin
            if (hit_scr && (widx == 32'(i))) begin
                rd_word = scratch_q[i];
            end
        end
    end

    assign rd_data = (rd_word >> bit_off) & size_mask(io_cmd_size_i);

    // Next values of the device state and response data for an accepted command.
    always_comb begin
        resp_data_d = resp_data_q;
        finish_d    = finish_q;
        pass_d      = pass_q;
        error_d     = error_q;
        for (int i = 0; i < num_scratch_p; i++) begin
            scratch_d[i] = scratch_q[i];
        end
        if (accept) begin
            resp_data_d = is_rd ? rd_data : 64'd0;
            if (unmapped) begin
                error_d = 1'b1;
            end
            for (int c = 0; c < num_core_p; c++) begin
                if (is_wr && hit_fin && (widx == 32'(c))) begin
                    finish_d[c] = 1'b1;
                    pass_d[c]   = io_cmd_data_i[0];
                end
            end
            for (int i = 0; i < num_scratch_p; i++) begin
                if (is_wr && hit_scr && (widx == 32'(i))) begin
                    scratch_d[i] = (scratch_q[i] & ~wr_mask) | (wr_data & wr_mask);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: putchar writes wait on the sink before responding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            e_ready: if (io_cmd_v_i)     state_d = char_wr ? e_char : e_resp;
            e_char:  if (char_ready_i)   state_d = e_resp;
            e_resp:  if (io_resp_yumi_i) state_d = e_ready;
            default:                     state_d = e_ready;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        io_cmd_ready_o = 1'b0;
        io_resp_v_o    = 1'b0;
        char_v_o       = 1'b0;
        case (state_q)
            e_ready: io_cmd_ready_o = 1'b1;
            e_char:  char_v_o       = 1'b1;
            e_resp:  io_resp_v_o    = 1'b1;
            default: ;
        endcase
    end

    // Header latch, device state and the free-running counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            msg_type_q  <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            payload_q   <= '0;
            char_q      <= '0;
            resp_data_q <= '0;
            cnt_q       <= '0;
            finish_q    <= '0;
            pass_q      <= '0;
            error_q     <= 1'b0;
            for (int i = 0; i < num_scratch_p; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_q + 64'd1;
            resp_data_q <= resp_data_d;
            finish_q    <= finish_d;
            pass_q      <= pass_d;
            error_q     <= error_d;
            for (int i = 0; i < num_scratch_p; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
            if (accept) begin
                msg_type_q <= io_cmd_msg_type_i;
                addr_q     <= io_cmd_addr_i;
                size_q     <= io_cmd_size_i;
                payload_q  <= io_cmd_payload_i;
                char_q     <= io_cmd_data_i[7:0];
            end
        end
    end

    assign io_resp_msg_type_o = msg_type_q;
    assign io_resp_addr_o     = addr_q;
    assign io_resp_size_o     = size_q;
    assign io_resp_payload_o  = payload_q;
    assign io_resp_data_o     = resp_data_q;
    assign char_o             = char_q;
    assign finish_o           = finish_q;
    assign pass_o             = pass_q;
    assign error_o            = error_q;

endmodule

// File: tb/tb_bp_io_mmio_responder.sv
// Directed bench for bp_io_mmio_responder: stimulus pushes the expected
// response into a queue, an independent monitor pops and compares each
// response the DUT presents.

module tb_bp_io_mmio_responder;

    localparam int PW = 40;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [3:0]    io_cmd_msg_type_i;
    logic [PW-1:0] io_cmd_addr_i;
    logic [2:0]    io_cmd_size_i;
    logic [15:0]   io_cmd_payload_i;
    logic [63:0]   io_cmd_data_i;
    logic          io_cmd_v_i;
    logic          io_cmd_ready_o;
    logic [3:0]    io_resp_msg_type_o;
    logic [PW-1:0] io_resp_addr_o;
    logic [2:0]    io_resp_size_o;
    logic [15:0]   io_resp_payload_o;
    logic [63:0]   io_resp_data_o;
    logic          io_resp_v_o;
    logic          io_resp_yumi_i;
    logic [7:0]    char_o;
    logic          char_v_o;
    logic          char_ready_i;
    logic [0:0]    finish_o;
    logic [0:0]    pass_o;
    logic          error_o;

    always #5 clk = ~clk;

    bp_io_mmio_responder #(
        .num_core_p(1), .paddr_width_p(PW), .num_scratch_p(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .io_cmd_msg_type_i(io_cmd_msg_type_i), .io_cmd_addr_i(io_cmd_addr_i),
        .io_cmd_size_i(io_cmd_size_i), .io_cmd_payload_i(io_cmd_payload_i),
        .io_cmd_data_i(io_cmd_data_i), .io_cmd_v_i(io_cmd_v_i),
        .io_cmd_ready_o(io_cmd_ready_o),
        .io_resp_msg_type_o(io_resp_msg_type_o), .io_resp_addr_o(io_resp_addr_o),
        .io_resp_size_o(io_resp_size_o), .io_resp_payload_o(io_resp_payload_o),
        .io_resp_data_o(io_resp_data_o), .io_resp_v_o(io_resp_v_o),
        .io_resp_yumi_i(io_resp_yumi_i),
        .char_o(char_o), .char_v_o(char_v_o), .char_ready_i(char_ready_i),
        .finish_o(finish_o), .pass_o(pass_o), .error_o(error_o)
    );

    typedef struct {
        logic [3:0]    t;
        logic [PW-1:0] a;
        logic [2:0]    s;
        logic [15:0]   p;
        logic [63:0]   d;
        bit            cap;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] cap_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          yumi_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Response monitor: compare whatever the DUT presents against the queue head, then consume it.
    initial begin
        exp_t e;
        io_resp_yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            io_resp_yumi_i = 1'b0;
            if (yumi_en && io_resp_v_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_hdr",
                          {1'b0, io_resp_msg_type_o, io_resp_addr_o, io_resp_size_o, io_resp_payload_o},
                          {1'b0, e.t, e.a, e.s, e.p});
                    if (e.cap) cap_q.push_back(io_resp_data_o);
                    else       check("resp_data", io_resp_data_o, e.d);
                end
                io_resp_yumi_i = 1'b1;
            end
        end
    end

    // Present one command (called at a negedge) and hold it until accepted.
    task automatic issue(input logic [3:0] t, input logic [PW-1:0] a, input logic [2:0] s,
                         input logic [15:0] p, input logic [63:0] d, input logic [63:0] x,
                         input bit cap, input bit push, output int acc);
        exp_t e;
        e.t = t; e.a = a; e.s = s; e.p = p; e.d = x; e.cap = cap;
        if (push) exp_q.push_back(e);
        io_cmd_msg_type_i = t;
        io_cmd_addr_i     = a;
        io_cmd_size_i     = s;
        io_cmd_payload_i  = p;
        io_cmd_data_i     = d;
        io_cmd_v_i        = 1'b1;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (io_cmd_ready_o === 1'b1) begin
                @(posedge clk);
                acc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        io_cmd_v_i = 1'b0;
        if (acc < 0) check("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || io_cmd_ready_o !== 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic txn(input logic [3:0] t, input logic [PW-1:0] a, input logic [2:0] s,
                       input logic [15:0] p, input logic [63:0] d, input logic [63:0] x);
        int acc;
        issue(t, a, s, p, d, x, 1'b0, 1'b1, acc);
        wait_idle();
    endtask

    initial begin
        int acc1, acc2, accx, n;
        reset_i = 1'b1;
        io_cmd_msg_type_i = '0; io_cmd_addr_i = '0; io_cmd_size_i = '0;
        io_cmd_payload_i = '0; io_cmd_data_i = '0; io_cmd_v_i = 1'b0;
        char_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;

        // Values out of reset
        check("rst_ready", 64'(io_cmd_ready_o), 64'd1);
        check("rst_resp_v", 64'(io_resp_v_o), 64'd0);
        check("rst_char_v", 64'(char_v_o), 64'd0);
        check("rst_flags", {61'd0, finish_o, pass_o, error_o}, 64'd0);
        check("rst_resp_hdr", {1'b0, io_resp_msg_type_o, io_resp_addr_o, io_resp_size_o, io_resp_payload_o}, 64'd0);
        check("rst_resp_data", io_resp_data_o, 64'd0);

        // Scratch write / read / partial merges
        txn(4'd3, 40'h3008, 3'd3, 16'hA5A5, 64'h1122334455667788, 64'd0);
        txn(4'd2, 40'h3008, 3'd3, 16'h1234, 64'd0, 64'h1122334455667788);
        txn(4'd3, 40'h300A, 3'd1, 16'h0001, 64'h000000000000BEEF, 64'd0);
        txn(4'd2, 40'h3008, 3'd3, 16'h0002, 64'd0, 64'h11223344BEEF7788);
        txn(4'd2, 40'h300C, 3'd0, 16'h0003, 64'd0, 64'h0000000000000044);
        txn(4'd0, 40'hAB00003008, 3'd2, 16'hFFFF, 64'd0, 64'h00000000BEEF7788);
        txn(4'd3, 40'h300E, 3'd3, 16'h0004, 64'hAABBCCDDEEFF0011, 64'd0);
        txn(4'd2, 40'h3008, 3'd3, 16'h0005, 64'd0, 64'h00113344BEEF7788);
        txn(4'd2, 40'h300E, 3'd7, 16'h0006, 64'd0, 64'h0000000000000011);
        txn(4'd1, 40'h3038, 3'd2, 16'h0007, 64'hDEADBEEFCAFEF00D, 64'd0);
        txn(4'd2, 40'h3038, 3'd3, 16'h0008, 64'd0, 64'h00000000CAFEF00D);
        txn(4'd2, 40'h3010, 3'd3, 16'h0009, 64'd0, 64'd0);

        // Putchar with a stalled sink
        char_ready_i = 1'b0;
        issue(4'd3, 40'h0000, 3'd0, 16'h00C0, 64'h41, 64'd0, 1'b0, 1'b1, accx);
        for (int k = 0; k < 5; k++) begin
            check("char_v_stall", 64'(char_v_o), 64'd1);
            check("char_o_stall", 64'(char_o), 64'h41);
            check("char_ready_low", {62'd0, io_cmd_ready_o, io_resp_v_o}, 64'd0);
            @(negedge clk);
        end
        char_ready_i = 1'b1;
        check("char_v_last", 64'(char_v_o), 64'd1);
        check("char_o_last", 64'(char_o), 64'h41);
        @(negedge clk);
        check("char_resp_v", 64'(io_resp_v_o), 64'd1);
        check("char_v_drop", 64'(char_v_o), 64'd0);
        check("char_ready_resp", 64'(io_cmd_ready_o), 64'd0);
        wait_idle();
        txn(4'd2, 40'h0010, 3'd3, 16'h00C1, 64'd0, 64'd0);

        // Finish / pass flags
        check("finish_init", {62'd0, finish_o, pass_o}, 64'd0);
        txn(4'd3, 40'h2000, 3'd3, 16'h00F0, 64'd1, 64'd0);
        check("finish_pass_1", {62'd0, finish_o, pass_o}, 64'd3);
        txn(4'd3, 40'h2000, 3'd3, 16'h00F1, 64'd0, 64'd0);
        check("finish_pass_0", {62'd0, finish_o, pass_o}, 64'd2);
        txn(4'd2, 40'h2000, 3'd3, 16'h00F2, 64'd0, 64'd0);

        // Counter write ignored, no-op type on an unmapped address: neither flags an error
        txn(4'd3, 40'h1000, 3'd3, 16'h0100, 64'hFFFF, 64'd0);
        txn(4'd5, 40'h5000, 3'd3, 16'h0101, 64'h1234, 64'd0);
        check("no_error_yet", 64'(error_o), 64'd0);

        // Cycle counter delta between two reads
        issue(4'd2, 40'h1000, 3'd3, 16'h0200, 64'd0, 64'd0, 1'b1, 1'b1, acc1);
        wait_idle();
        repeat (7) @(negedge clk);
        issue(4'd2, 40'h1000, 3'd3, 16'h0201, 64'd0, 64'd0, 1'b1, 1'b1, acc2);
        wait_idle();
        check("cnt_captures", 64'(cap_q.size()), 64'd2);
        if (cap_q.size() == 2)
            check("cnt_delta", cap_q[1] - cap_q[0], 64'(acc2 - acc1));

        // Unmapped accesses set a sticky error
        txn(4'd2, 40'h5000, 3'd3, 16'h0300, 64'd0, 64'd0);
        check("error_set", 64'(error_o), 64'd1);
        txn(4'd2, 40'h3040, 3'd3, 16'h0301, 64'd0, 64'd0);
        txn(4'd2, 40'h3008, 3'd3, 16'h0302, 64'd0, 64'h00113344BEEF7788);
        check("error_sticky", 64'(error_o), 64'd1);

        // Reset while a response is pending
        yumi_en = 1'b0;
        issue(4'd2, 40'h3008, 3'd3, 16'h0400, 64'd0, 64'd0, 1'b0, 1'b0, accx);
        n = 0;
        while (io_resp_v_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("pend_resp_v", 64'(io_resp_v_o), 64'd1);
        reset_i = 1'b1;
        @(negedge clk);
        check("mid_rst_resp_v", 64'(io_resp_v_o), 64'd0);
        check("mid_rst_ready", 64'(io_cmd_ready_o), 64'd1);
        reset_i = 1'b0;
        yumi_en = 1'b1;
        check("mid_rst_flags", {61'd0, finish_o, pass_o, error_o}, 64'd0);
        txn(4'd2, 40'h3008, 3'd3, 16'h0401, 64'd0, 64'd0);
        txn(4'd2, 40'h3038, 3'd3, 16'h0402, 64'd0, 64'd0);

        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_io_mmio_responder.md
Name: bp_io_mmio_responder

Overview:
- Synthesizable responder for the processor's outbound uncached I/O command channel (io_cmd_o / io_resp_i side of bsg_chip).
- Decodes single-beat uncached loads and stores against a small device map: putchar stream, per-core finish/pass flags, free-running cycle counter, scratch registers.
- Replaces the non-synthesizable host model on FPGA/emulation builds, so the interface is identical on the command/response side.
- At most one command is outstanding at any time.

Parameters:
- num_core_p, 1, number of cores; sizes the finish/pass vectors.
- paddr_width_p, 40, physical address width.
- num_scratch_p, 8, number of 64-bit scratch registers; must be a power of 2 and at most 64.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- io_cmd_msg_type_i  in  4  command type: 0=rd, 1=wr, 2=uc_rd, 3=uc_wr, others=no-op
- io_cmd_addr_i  in  paddr_width_p  byte address
- io_cmd_size_i  in  3  access size: 0=1B, 1=2B, 2=4B, 3=8B, >3 treated as 8B
- io_cmd_payload_i  in  16  opaque header payload; echoed in the response
- io_cmd_data_i  in  64  store data, right-justified
- io_cmd_v_i  in  1  command valid
- io_cmd_ready_o  out  1  ready to accept a command
- io_resp_msg_type_o / io_resp_addr_o / io_resp_size_o / io_resp_payload_o  out  4/paddr_width_p/3/16  echoed command header
- io_resp_data_o  out  64  load data
- io_resp_v_o  out  1  response valid
- io_resp_yumi_i  in  1  response consumed
- char_o  out  8  putchar byte
- char_v_o  out  1  putchar valid
- char_ready_i  in  1  putchar sink ready
- finish_o  out  num_core_p  sticky per-core finish flags
- pass_o  out  num_core_p  sticky per-core pass flags
- error_o  out  1  sticky flag: an unmapped address was accessed

Behaviour:
- Address decode uses addr[15:0]; upper address bits are ignored.
  - 0x0000-0x0FFF: putchar.
  - 0x1000-0x1007: cycle counter, read-only.
  - 0x2000 + 8*c, for c < num_core_p: finish for core c.
  - 0x3000 + 8*i, for i < num_scratch_p: scratch register i.
  - Anything else is unmapped.
- FSM states: e_ready, e_char, e_resp. Reset state is e_ready.
- e_ready:
  - io_cmd_ready_o=1.
  - On io_cmd_v_i: latch the header and data.
  - If the command is a putchar write, go to e_char. Otherwise perform the access in this cycle and go to e_resp.
- e_char:
  - char_v_o=1; char_o = latched data[7:0].
  - On char_ready_i, go to e_resp.
  - The command is not acknowledged until the byte is accepted.
- e_resp:
  - io_resp_v_o=1.
  - On io_resp_yumi_i, go to e_ready.
  - io_cmd_ready_o=0 in e_char and e_resp.
  - Minimum spacing between commands is 2 cycles.
- The response header echoes the latched command fields exactly.
- Read data:
  - Select the 64-bit word, shift right by 8*addr[2:0], mask to the access size (zero-extend).
  - Writes, no-op types, putchar reads, and finish reads all return 0.
- Scratch write: merge the low (size) bytes of data into the word at byte offset addr[2:0]; other bytes are unchanged. Bytes beyond byte 7 are dropped.
- Finish write to core c: finish_o[c] <= 1; pass_o[c] <= data[0].
  - A later write re-sets finish and overwrites pass.
- Cycle counter:
  - 64-bit, increments every cycle out of reset, wraps at 2^64-1 -> 0.
  - A read returns the value sampled at command acceptance.
  - Writes to the counter are ignored and do not set error_o.
- Unmapped access: writes are dropped, reads return 0, error_o <= 1.
- No-op message types: respond with data 0; no state change; no error.
- Values after reset:
  - io_cmd_ready_o=1; io_resp_v_o=0; char_v_o=0.
  - finish_o, pass_o, error_o, scratch registers, counter all 0.
  - Response fields are 0.
- Reset asserted mid-transaction (e_char or e_resp): the transaction is discarded with no response, and the FSM returns to e_ready on the next edge.
- io_cmd_v_i outside e_ready is ignored. The source must hold the command until it sees ready.

Test Plan:
- uc_wr addr 0x3008, size 3, data 0x1122334455667788; then uc_rd 0x3008 size 3 -> resp data 0x1122334455667788, payload echoed.
- uc_wr 0x300A size 1 data 0xBEEF over the previous value; uc_rd 0x3008 size 3 -> 0x11223344BEEF7788; uc_rd 0x300C size 0 -> 0x44.
- uc_wr 0x0000 data 0x41 with char_ready_i held low 5 cycles -> char_v_o=1 with char_o=0x41 for 6 cycles; io_resp_v_o rises the cycle after char_ready_i; io_cmd_ready_o=0 throughout.
- uc_wr 0x2000 data 1, num_core_p=1 -> finish_o=1, pass_o=1; then write data 0 -> finish_o=1, pass_o=0.
- Two uc_rd of 0x1000 accepted N cycles apart -> data difference equals N; uc_rd 0x5000 -> data 0, error_o=1 and it stays 1.
- Reset pulsed while in e_resp with io_resp_yumi_i low -> next cycle io_resp_v_o=0, io_cmd_ready_o=1, scratch reads return 0.
